serial_rx: RTL and testbench

Asynchronous serial receiver that deserialises the frames produced by the team's serial transmitter. It sits on the receive side of the serial I/O path, between the rx pin and the parallel consumer logic. It hunts for a start bit, samples each data bit at mid-period, checks the stop bit, and presents the word with a one-cycle valid or framing-error pulse. Bit timing matches the transmitter: one bit = 2^TimerWidth clocks.

---
 rtl/serial_rx_pkg.sv | 23 ++
 rtl/serial_rx_sync.sv | 32 +++
 rtl/serial_rx.sv | 149 ++++++++++++++
 tb/tb_serial_rx.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial receiver: FSM states, idle line level and
// bit-period helpers derived from the timer width.
package serial_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_e;

  localparam logic LINE_IDLE = 1'b1;

  function automatic int unsigned full_period(input int unsigned timer_width);
    return 32'd1 << timer_width;
  endfunction

  function automatic int unsigned half_period(input int unsigned timer_width);
    return 32'd1 << (timer_width - 1);
  endfunction

endpackage

// File: rtl/serial_rx_sync.sv
// Two-flop synchroniser for the rx pin plus falling-edge detector; all flops
// reset to the idle line level so reset never fakes a start bit.
module serial_rx_sync
  import serial_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic line_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= LINE_IDLE;
      sync_q <= LINE_IDLE;
      prev_q <= LINE_IDLE;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign line_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/serial_rx.sv
// Asynchronous serial receiver: start hunt, mid-bit sampling, stop check.
// Optional SERIAL_RX_MAJORITY_EN: 2-of-3 vote around each sample, +1 clk latency.
module serial_rx
  import serial_rx_pkg::*;
#(
  parameter int unsigned Width      = 8,
  parameter int unsigned TimerWidth = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  output logic [Width-1:0] Q,
  output logic             valid,
  output logic             ferr,
  output logic             busy
);

  localparam int unsigned BitCntW = $clog2(Width + 1);
  localparam logic [BitCntW-1:0] LastBit = BitCntW'(Width - 1);

  logic line;
  logic fall;
  logic sample;

  serial_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .rx_i   (rx),
    .line_o (line),
    .fall_o (fall)
  );

`ifdef SERIAL_RX_MAJORITY_EN
  localparam int unsigned MajDelay = 1;
  logic hist1_q;
  logic hist2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist1_q <= LINE_IDLE;
      hist2_q <= LINE_IDLE;
    end else begin
      hist1_q <= line;
      hist2_q <= hist1_q;
    end
  end

  // Decision is taken one clock late so the vote spans point -1, 0, +1.
  assign sample = (hist2_q & hist1_q) | (hist2_q & line) | (hist1_q & line);
`else
  localparam int unsigned MajDelay = 0;
  assign sample = line;
`endif

  // Full-period match wraps to 0 when delayed, matching the natural timer wrap.
  localparam logic [TimerWidth-1:0] StartAt = TimerWidth'(half_period(TimerWidth) - 1 + MajDelay);
  localparam logic [TimerWidth-1:0] BitAt   = TimerWidth'(full_period(TimerWidth) - 1 + MajDelay);
  localparam logic [TimerWidth-1:0] DataRestart = TimerWidth'(MajDelay);

  state_e               state_q, state_d;
  logic [TimerWidth-1:0] timer_q, timer_d;
  logic [BitCntW-1:0]    bitcnt_q, bitcnt_d;
  logic [Width-1:0]      shift_q, shift_d;
  logic [Width-1:0]      q_q, q_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      q_q      <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      q_q      <= q_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + 1'b1;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    q_d      = q_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        timer_d  = '0;
        bitcnt_d = '0;
        if (fall) state_d = ST_START;
      end
      ST_START: begin
        if (timer_q == StartAt) begin
          if (sample == 1'b0) begin
            state_d  = ST_DATA;
            timer_d  = DataRestart;
            bitcnt_d = '0;
          end else begin
            state_d = ST_IDLE;
            timer_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (timer_q == BitAt) begin
          shift_d = {sample, shift_q[Width-1:1]};
          if (bitcnt_q == LastBit) state_d = ST_STOP;
          else                     bitcnt_d = bitcnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (timer_q == BitAt) begin
          if (sample) begin
            q_d     = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        timer_d = '0;
        if (line == LINE_IDLE) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign Q     = q_q;
  assign valid = valid_q;
  assign ferr  = ferr_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx (Width=8, TimerWidth=4): table vectors,
// hand-written corner sequences and random frames against a timing/data model.
module tb_serial_rx;

  localparam int W  = 8;
  localparam int TW = 4;
  localparam int P  = 16;
  localparam int H  = 8;
`ifdef SERIAL_RX_MAJORITY_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] Q;
  logic       valid;
  logic       ferr;
  logic       busy;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   vcount = 0;
  int   fcount = 0;
  int   vtime = 0;
  int   ftime = 0;
  logic [7:0] vdata = '0;
  int   both_seen = 0;

  serial_rx #(.Width(W), .TimerWidth(TW)) dut (
    .clk   (clk),
    .rst   (rst),
    .rx    (rx),
    .Q     (Q),
    .valid (valid),
    .ferr  (ferr),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      vcount = vcount + 1;
      vtime  = cyc;
      vdata  = Q;
    end
    if (ferr) begin
      fcount = fcount + 1;
      ftime  = cyc;
    end
    if (valid && ferr) both_seen = 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Line-level frame generator; a bit is P clocks, data LSB first.
  // Glitch inverts one clock exactly at the mid-bit point of each data bit.
  task automatic send_frame(input logic [7:0] d, input bit ok, input int hold,
                            input bit glitch, output int c);
    c  = cyc;
    rx = 1'b0;
    repeat (P) @(negedge clk);
    for (int k = 0; k < W; k++) begin
      rx = d[k];
      if (glitch) begin
        repeat (H) @(negedge clk);
        rx = ~d[k];
        @(negedge clk);
        rx = d[k];
        repeat (P - H - 1) @(negedge clk);
      end else begin
        repeat (P) @(negedge clk);
      end
    end
    if (ok) begin
      rx = 1'b1;
      repeat (P) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (hold) @(negedge clk);
      rx = 1'b1;
    end
  endtask

  // Stop decision lands at line-start + 2 sync + 1 detect + H + (W+1)P clocks.
  task automatic check_frame(input string tag, input int c, input int vb, input int fb,
                             input bit exp_v, input bit exp_f, input logic [7:0] exp_q);
    int e;
    e = c + 3 + H + (W + 1) * P + LAT;
    chk({tag, ".valid_cnt"}, vcount - vb, int'(exp_v));
    chk({tag, ".ferr_cnt"}, fcount - fb, int'(exp_f));
    if (exp_v) begin
      chk({tag, ".valid_time"}, vtime, e);
      chk({tag, ".valid_data"}, int'(vdata), int'(exp_q));
    end else if (exp_f) begin
      chk({tag, ".ferr_time"}, ftime, e);
    end
    chk({tag, ".Q"}, int'(Q), int'(exp_q));
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ok;
    int         hold;
    int         gap;
    bit         exp_v;
    bit         exp_f;
    logic [7:0] exp_q;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int c, vb, fb, gap, hold;
    bit ok;
    bit glitch_en;
    logic [7:0] d;
    logic [7:0] model_q;

    glitch_en = (LAT != 0);
    tbl[0] = '{8'hA5, 1'b1, P, 6, 1'b1, 1'b0, 8'hA5};
    tbl[1] = '{8'h3C, 1'b0, P, 6, 1'b0, 1'b1, 8'hA5};
    tbl[2] = '{8'h00, 1'b1, P, 0, 1'b1, 1'b0, 8'h00};
    tbl[3] = '{8'hFF, 1'b1, P, 5, 1'b1, 1'b0, 8'hFF};
    tbl[4] = '{8'h01, 1'b1, P, 0, 1'b1, 1'b0, 8'h01};
    tbl[5] = '{8'h80, 1'b1, P, 0, 1'b1, 1'b0, 8'h80};
    tbl[6] = '{8'hFF, 1'b1, P, 4, 1'b1, 1'b0, 8'hFF};

    repeat (3) @(negedge clk);
    chk("reset.Q", int'(Q), 0);
    chk("reset.valid", int'(valid), 0);
    chk("reset.ferr", int'(ferr), 0);
    chk("reset.busy", int'(busy), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      vb = vcount;
      fb = fcount;
      send_frame(tbl[i].data, tbl[i].ok, tbl[i].hold, glitch_en, c);
      check_frame($sformatf("tbl%0d", i), c, vb, fb, tbl[i].exp_v, tbl[i].exp_f, tbl[i].exp_q);
      repeat (tbl[i].gap) @(negedge clk);
    end

    // Short low glitch on idle line: false start, back to idle at mid-start.
    vb = vcount;
    fb = fcount;
    c  = cyc;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    chk("glitch.busy_rise", int'(busy), 1);
    repeat (6 + LAT) @(negedge clk);
    chk("glitch.busy_hold", int'(busy), 1);
    @(negedge clk);
    chk("glitch.busy_fall", int'(busy), 0);
    chk("glitch.fall_time", cyc, c + 3 + H + LAT);
    repeat (P) @(negedge clk);
    chk("glitch.no_valid", vcount - vb, 0);
    chk("glitch.no_ferr", fcount - fb, 0);
    chk("glitch.Q", int'(Q), 8'hFF);

    // Bad stop with line held low 40 clocks: ferr once, busy until line high.
    vb = vcount;
    fb = fcount;
    send_frame(8'h3C, 1'b0, 40, 1'b0, c);
    check_frame("break", c, vb, fb, 1'b0, 1'b1, 8'hFF);
    chk("break.busy_low_line", int'(busy), 1);
    repeat (3) @(negedge clk);
    chk("break.busy_released", int'(busy), 0);
    repeat (4) @(negedge clk);

    // Reset in the middle of DATA of 0x55, then a clean 0x81.
    vb = vcount;
    fb = fcount;
    d  = 8'h55;
    rx = 1'b0;
    repeat (P) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      rx = d[k];
      repeat (P) @(negedge clk);
    end
    chk("rst.busy_before", int'(busy), 1);
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    chk("rst.Q", int'(Q), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.valid", int'(valid), 0);
    chk("rst.ferr", int'(ferr), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (P + 4) @(negedge clk);
    chk("rst.no_pulse", (vcount - vb) + (fcount - fb), 0);
    vb = vcount;
    fb = fcount;
    send_frame(8'h81, 1'b1, P, glitch_en, c);
    check_frame("rst.after", c, vb, fb, 1'b1, 1'b0, 8'h81);
    repeat (3) @(negedge clk);

    // Random frames: model keeps the last good word; bad stops leave it alone.
    model_q = 8'h81;
    for (int i = 0; i < 25; i++) begin
      d    = 8'($urandom_range(0, 255));
      ok   = ($urandom_range(0, 5) != 0);
      hold = P + int'($urandom_range(0, 24));
      gap  = ok ? int'($urandom_range(0, 8)) : int'($urandom_range(4, 12));
      if (ok) model_q = d;
      vb = vcount;
      fb = fcount;
      send_frame(d, ok, hold, glitch_en, c);
      check_frame($sformatf("rnd%0d", i), c, vb, fb, ok, !ok, model_q);
      repeat (gap) @(negedge clk);
    end

    repeat (P) @(negedge clk);
    chk("pulse_exclusive", both_seen, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
